// File: rtl/mcseq_pkg.sv
// Shared types and instruction-class bit positions for the multi-cycle sequencer.
// The optional performance counters are enabled with the MCSEQ_PERF_EN macro.
package mcseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam int IDX_JR  = 16;
  localparam int IDX_LW  = 22;
  localparam int IDX_SW  = 23;
  localparam int IDX_BEQ = 24;
  localparam int IDX_BNE = 25;
  localparam int IDX_J   = 29;
  localparam int IDX_JAL = 30;

  // A zero vector is not one-hot; clearing the lowest set bit must leave nothing.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mcseq_perf.sv
// Cycle and retirement counters for the sequencer; both wrap at 32 bits.
// Instantiated only when MCSEQ_PERF_EN is defined.
module mcseq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_en,
  input  logic        ret_en,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      if (cyc_en) cyc_cnt <= cyc_cnt + 32'd1;
      if (ret_en) ret_cnt <= ret_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mcseq_ctrl.sv
// Multi-cycle MIPS sequencer: steps instructions through FETCH/DECODE/EXEC/MEM/WB
// and fires state-changing strobes. Optional counters under MCSEQ_PERF_EN.
module mcseq_ctrl
  import mcseq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i,
  input  logic        z,
  input  logic        stall,
  input  logic        im_ack,
  input  logic        dm_ack,
  output logic        im_req,
  output logic        ir_we,
  output logic        pc_inc_we,
  output logic        pc_br_we,
  output logic        rf_we,
  output logic        wb_sel_mem,
  output logic        dm_cs,
  output logic        dm_r,
  output logic        dm_w,
  output logic        retire,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  state_t st_q, st_d;
  logic   from_mem_q;

  // Strobes are same-cycle functions of state and acks, so the reset path
  // (state forced to IDLE) drops every strobe, including dm_cs, asynchronously.
  always_comb begin
    st_d       = st_q;
    im_req     = 1'b0;
    ir_we      = 1'b0;
    pc_inc_we  = 1'b0;
    pc_br_we   = 1'b0;
    rf_we      = 1'b0;
    wb_sel_mem = 1'b0;
    dm_cs      = 1'b0;
    dm_r       = 1'b0;
    dm_w       = 1'b0;
    retire     = 1'b0;
    err        = 1'b0;
    case (st_q)
      S_IDLE: st_d = S_FETCH;
      S_FETCH: begin
        im_req = ~stall;
        if (im_ack && !stall) begin
          ir_we     = 1'b1;
          pc_inc_we = 1'b1;
          st_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_onehot(i)) begin
          st_d = S_ERR;
        end else if (i[IDX_J] || i[IDX_JR] || i[IDX_JAL]) begin
          pc_br_we = 1'b1;
          rf_we    = i[IDX_JAL];
          retire   = 1'b1;
          st_d     = S_FETCH;
        end else begin
          st_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i[IDX_BEQ] || i[IDX_BNE]) begin
          pc_br_we = (i[IDX_BEQ] & z) | (i[IDX_BNE] & ~z);
          retire   = 1'b1;
          st_d     = S_FETCH;
        end else if (i[IDX_LW] || i[IDX_SW]) begin
          st_d = S_MEM;
        end else begin
          st_d = S_WB;
        end
      end
      S_MEM: begin
        dm_cs = 1'b1;
        dm_r  = i[IDX_LW];
        dm_w  = i[IDX_SW];
        if (dm_ack) begin
          if (i[IDX_SW]) begin
            retire = 1'b1;
            st_d   = S_FETCH;
          end else begin
            st_d = S_WB;
          end
        end
      end
      // WB is reached from MEM only for loads, so the source select needs no look at i.
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel_mem = from_mem_q;
        retire     = 1'b1;
        st_d       = S_FETCH;
      end
      S_ERR:   err  = 1'b1;
      default: st_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      from_mem_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      from_mem_q <= (st_q == S_MEM);
    end
  end

  assign state = st_q;

`ifdef MCSEQ_PERF_EN
  mcseq_perf u_perf (
    .clk     (clk),
    .rst_n   (rst_n),
    .cyc_en  ((st_q != S_IDLE) && (st_q != S_ERR)),
    .ret_en  (retire),
    .cyc_cnt (cyc_cnt),
    .ret_cnt (ret_cnt)
  );
`else
  assign cyc_cnt = 32'd0;
  assign ret_cnt = 32'd0;
`endif

endmodule
